// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt sequencer: FSM state codes,
// command word indices, OCW2 command codes and a priority-encode helper.
package pic_pkg;

  // FSM state codes
  localparam logic [2:0] ST_UNINIT = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_PEND   = 3'd2;
  localparam logic [2:0] ST_ACK1   = 3'd3;
  localparam logic [2:0] ST_ACK2   = 3'd4;

  // cfg_nr encodings when cfg_type = 1 (ICW)
  localparam logic [1:0] ICW1_NR = 2'd0;
  localparam logic [1:0] ICW2_NR = 2'd1;
  localparam logic [1:0] ICW3_NR = 2'd2;
  localparam logic [1:0] ICW4_NR = 2'd3;

  // cfg_nr encodings when cfg_type = 0 (OCW)
  localparam logic [1:0] OCW1_NR = 2'd0;
  localparam logic [1:0] OCW2_NR = 2'd1;
  localparam logic [1:0] OCW3_NR = 2'd2;

  // OCW2 bits [7:5]
  localparam logic [2:0] OCW2_NS_EOI = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI = 3'b011;

  // Index of the lowest set bit (highest priority); 7 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver.
// Ports:
//   irr, imr, isr  in   8  request, mask and in-service registers
//   winner_valid   out  1  an unmasked request may interrupt the CPU now
//   winner         out  3  index of the highest-priority unmasked request
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  output logic       winner_valid,
  output logic [2:0] winner
);

  logic [7:0] w_req;
  logic [2:0] w_isr_top;

  assign w_req = irr & ~imr;

  always_comb begin
    winner    = lowest_set(w_req);
    w_isr_top = lowest_set(isr);
    // A request only nests over an in-service level of strictly lower priority.
    winner_valid = (|w_req) && ((isr == 8'h00) || (winner < w_isr_top));
  end

endmodule

// File: rtl/pic_int_sequencer.sv
// 8-input interrupt controller core: request capture, priority resolution,
// two-pulse INTA acknowledge sequence and vector generation.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ir[7:0]                    request lines, IR0 highest priority
//   inta_n                     async acknowledge strobe from the CPU
//   cfg_valid/type/nr/data     decoded command word (ICW/OCW) strobe
//   int_out                    interrupt request to the CPU
//   vec_data, vec_oe           vector byte and its bus drive enable
//   irr_out, isr_out, imr_out  live register read-back
module pic_int_sequencer
  import pic_pkg::*;
#(
  parameter int INTA_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       inta_n,
  input  logic       cfg_valid,
  input  logic       cfg_type,
  input  logic [1:0] cfg_nr,
  input  logic [7:0] cfg_data,
  output logic       int_out,
  output logic [7:0] vec_data,
  output logic       vec_oe,
  output logic [7:0] irr_out,
  output logic [7:0] isr_out,
  output logic [7:0] imr_out
);

  logic [INTA_SYNC-1:0] r_inta_sync;
  logic       r_inta_prev;
  logic [7:0] r_ir_prev;
  logic [2:0] r_state;
  logic [7:0] r_irr, r_isr, r_imr;
  logic [4:0] r_base;
  logic       r_ltim, r_aeoi;
  logic [2:0] r_level, r_pend_level;
  logic       r_int_out, r_vec_oe;
  logic [7:0] r_vec_data;

  logic       w_inta_s, w_inta_fall, w_inta_rise;
  logic       w_icw1, w_icw2, w_icw4, w_ocw1, w_ocw2;
  logic       w_winner_valid;
  logic [2:0] w_winner;
  logic [7:0] w_irr_in, w_irr_clr, w_isr_set, w_isr_clr;
  logic [2:0] w_state_nxt, w_level_nxt, w_pend_nxt;
  logic       w_int_nxt, w_vec_oe_nxt;
  logic [7:0] w_vec_data_nxt;

  assign w_inta_s    = r_inta_sync[INTA_SYNC-1];
  assign w_inta_fall = r_inta_prev & ~w_inta_s;
  assign w_inta_rise = ~r_inta_prev & w_inta_s;

  // Edge mode accumulates rising edges; level mode follows the pin directly.
  assign w_irr_in = r_ltim ? ir : (r_irr | (ir & ~r_ir_prev));

  pic_priority_resolver u_resolver (
    .irr          (r_irr),
    .imr          (r_imr),
    .isr          (r_isr),
    .winner_valid (w_winner_valid),
    .winner       (w_winner)
  );

  // Command word decode.
  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_icw1 = 1'b0;
    w_icw2 = 1'b0;
    w_icw4 = 1'b0;
    w_ocw1 = 1'b0;
    w_ocw2 = 1'b0;
    if (cfg_valid) begin
      if (cfg_type) begin
        case (cfg_nr)
          ICW1_NR: w_icw1 = 1'b1;
          ICW2_NR: w_icw2 = 1'b1;
          ICW3_NR: ;  // no cascade: ICW3 is accepted and dropped
          ICW4_NR: w_icw4 = 1'b1;
        endcase
      end else begin
        case (cfg_nr)
          OCW1_NR: w_ocw1 = 1'b1;
          OCW2_NR: w_ocw2 = 1'b1;
          OCW3_NR: ;  // read-back is always live, select has no effect
          default: ;
        endcase
      end
    end
  end

  // Acknowledge sequencer and ISR/IRR update terms.
  always_comb begin
    w_state_nxt    = r_state;
    w_int_nxt      = r_int_out;
    w_vec_oe_nxt   = r_vec_oe;
    w_vec_data_nxt = r_vec_data;
    w_level_nxt    = r_level;
    w_pend_nxt     = r_pend_level;
    w_isr_set      = 8'h00;
    w_isr_clr      = 8'h00;
    w_irr_clr      = 8'h00;

    if (w_ocw2) begin
      if (cfg_data[7:5] == OCW2_NS_EOI && r_isr != 8'h00)
        w_isr_clr[lowest_set(r_isr)] = 1'b1;
      else if (cfg_data[7:5] == OCW2_SP_EOI)
        w_isr_clr[cfg_data[2:0]] = 1'b1;
    end

    case (r_state)
      ST_UNINIT: if (w_icw2) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_winner_valid) begin
          w_state_nxt = ST_PEND;
          w_int_nxt   = 1'b1;
          w_pend_nxt  = w_winner;
        end
      end
      ST_PEND: begin
        if (w_inta_fall) begin
          w_state_nxt = ST_ACK1;
          if (w_winner_valid) begin
            w_level_nxt           = w_winner;
            w_isr_set[w_winner]   = 1'b1;
            w_irr_clr[w_winner]   = 1'b1;
          end else begin
            w_level_nxt = 3'd7;  // spurious: request vanished before INTA
          end
        end else if (r_imr[r_pend_level]) begin
          w_state_nxt = ST_IDLE;
          w_int_nxt   = 1'b0;
        end
      end
      ST_ACK1: begin
        if (w_inta_fall) begin
          w_state_nxt    = ST_ACK2;
          w_vec_oe_nxt   = 1'b1;
          w_vec_data_nxt = {r_base, r_level};
        end
      end
      ST_ACK2: begin
        if (w_inta_rise) begin
          w_state_nxt  = ST_IDLE;
          w_vec_oe_nxt = 1'b0;
          w_int_nxt    = 1'b0;
          if (r_aeoi) w_isr_clr[r_level] = 1'b1;
        end
      end
      default: w_state_nxt = ST_UNINIT;
    endcase

    if (w_icw1) begin
      w_state_nxt  = ST_UNINIT;
      w_int_nxt    = 1'b0;
      w_vec_oe_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inta_sync  <= '1;
      r_inta_prev  <= 1'b1;
      r_ir_prev    <= 8'h00;
      r_state      <= ST_UNINIT;
      r_irr        <= 8'h00;
      r_isr        <= 8'h00;
      r_imr        <= 8'h00;
      r_base       <= 5'd0;
      r_ltim       <= 1'b0;
      r_aeoi       <= 1'b0;
      r_level      <= 3'd0;
      r_pend_level <= 3'd0;
      r_int_out    <= 1'b0;
      r_vec_oe     <= 1'b0;
      r_vec_data   <= 8'h00;
    end else begin
      r_inta_sync  <= {r_inta_sync[INTA_SYNC-2:0], inta_n};
      r_inta_prev  <= w_inta_s;
      r_ir_prev    <= ir;
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_pend_level <= w_pend_nxt;
      r_int_out    <= w_int_nxt;
      r_vec_oe     <= w_vec_oe_nxt;
      r_vec_data   <= w_vec_data_nxt;
      if (w_icw1) begin
        r_irr  <= 8'h00;
        r_isr  <= 8'h00;
        r_imr  <= 8'h00;
        r_ltim <= cfg_data[3];
      end else begin
        r_irr <= w_irr_in & ~w_irr_clr;
        // The ACK1 set is OR-ed last so it wins over a coincident EOI.
        r_isr <= (r_isr & ~w_isr_clr) | w_isr_set;
        if (w_ocw1) r_imr <= cfg_data;
      end
      if (w_icw2) r_base <= cfg_data[7:3];
      if (w_icw4) r_aeoi <= cfg_data[1];
    end
  end

  assign int_out  = r_int_out;
  assign vec_oe   = r_vec_oe;
  assign vec_data = r_vec_data;
  assign irr_out  = r_irr;
  assign isr_out  = r_isr;
  assign imr_out  = r_imr;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed bench for pic_int_sequencer: reset, basic acknowledge, priority,
// nesting block, level-mode spurious, masking in PEND, AEOI and mid-cycle reset.
module tb_pic_int_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir;
  logic       inta_n;
  logic       cfg_valid;
  logic       cfg_type;
  logic [1:0] cfg_nr;
  logic [7:0] cfg_data;
  logic       int_out;
  logic [7:0] vec_data;
  logic       vec_oe;
  logic [7:0] irr_out, isr_out, imr_out;

  int checks = 0;
  int errors = 0;

  pic_int_sequencer #(.INTA_SYNC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir        (ir),
    .inta_n    (inta_n),
    .cfg_valid (cfg_valid),
    .cfg_type  (cfg_type),
    .cfg_nr    (cfg_nr),
    .cfg_data  (cfg_data),
    .int_out   (int_out),
    .vec_data  (vec_data),
    .vec_oe    (vec_oe),
    .irr_out   (irr_out),
    .isr_out   (isr_out),
    .imr_out   (imr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- stimulus helpers (all driving happens at negedge) ----
  task automatic cfg_write(input logic typ, input logic [1:0] nr, input logic [7:0] data);
    cfg_valid = 1'b1;
    cfg_type  = typ;
    cfg_nr    = nr;
    cfg_data  = data;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic init(input logic [7:0] icw1, input logic [7:0] icw4);
    cfg_write(1'b1, 2'd0, icw1);
    cfg_write(1'b1, 2'd1, 8'h20);
    cfg_write(1'b1, 2'd3, icw4);
    cfg_write(1'b0, 2'd0, 8'h00);
  endtask

  task automatic pulse_ir(input logic [7:0] lines);
    ir = lines;
    @(negedge clk);
    ir = 8'h00;
  endtask

  // Full two-pulse acknowledge; returns ISR seen after ACK1 and the vector
  // bus seen while the second pulse is low.
  task automatic inta_ack(output logic [7:0] isr_a1, output logic [7:0] vec, output logic oe);
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    isr_a1 = isr_out;
    inta_n = 1'b1;
    repeat (4) @(negedge clk);
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    vec = vec_data;
    oe  = vec_oe;
    inta_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---- scenarios ----
  task automatic test_reset;
    checks++;
    if ({int_out, vec_oe, vec_data} !== 10'h000) begin
      errors++;
      $display("FAIL reset_outputs got int=%b oe=%b vec=%h exp 0/0/00", int_out, vec_oe, vec_data);
    end
    checks++;
    if ({irr_out, isr_out, imr_out} !== 24'h0) begin
      errors++;
      $display("FAIL reset_regs got irr=%h isr=%h imr=%h exp 00/00/00", irr_out, isr_out, imr_out);
    end
  endtask

  task automatic test_basic;
    logic [7:0] isr_a1, vec;
    logic oe;
    init(8'h13, 8'h01);
    ir = 8'h08;
    @(negedge clk);
    ir = 8'h00;
    checks++;
    if (int_out !== 1'b0 || irr_out !== 8'h08) begin
      errors++;
      $display("FAIL basic_cycle1 got int=%b irr=%h exp 0/08", int_out, irr_out);
    end
    @(negedge clk);
    checks++;
    if (int_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_int_latency got %b exp 1", int_out);
    end
    inta_ack(isr_a1, vec, oe);
    checks++;
    if (isr_a1 !== 8'h08) begin
      errors++;
      $display("FAIL basic_isr_ack1 got %h exp 08", isr_a1);
    end
    checks++;
    if (vec !== 8'h23 || oe !== 1'b1) begin
      errors++;
      $display("FAIL basic_vector got vec=%h oe=%b exp 23/1", vec, oe);
    end
    checks++;
    if (vec_oe !== 1'b0 || int_out !== 1'b0 || isr_out !== 8'h08 || irr_out !== 8'h00) begin
      errors++;
      $display("FAIL basic_after got oe=%b int=%b isr=%h irr=%h exp 0/0/08/00",
               vec_oe, int_out, isr_out, irr_out);
    end
  endtask

  task automatic test_priority;
    logic [7:0] isr_a1, vec;
    logic oe;
    init(8'h13, 8'h01);
    pulse_ir(8'h24);
    repeat (3) @(negedge clk);
    inta_ack(isr_a1, vec, oe);
    checks++;
    if (vec !== 8'h22 || isr_a1 !== 8'h04) begin
      errors++;
      $display("FAIL prio_first got vec=%h isr=%h exp 22/04", vec, isr_a1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (int_out !== 1'b0 || irr_out !== 8'h20) begin
      errors++;
      $display("FAIL prio_blocked got int=%b irr=%h exp 0/20", int_out, irr_out);
    end
    cfg_write(1'b0, 2'd1, 8'h20);
    repeat (3) @(negedge clk);
    inta_ack(isr_a1, vec, oe);
    checks++;
    if (vec !== 8'h25 || isr_a1 !== 8'h20) begin
      errors++;
      $display("FAIL prio_second got vec=%h isr=%h exp 25/20", vec, isr_a1);
    end
  endtask

  task automatic test_nesting;
    logic [7:0] isr_a1, vec;
    logic oe;
    init(8'h13, 8'h01);
    pulse_ir(8'h04);
    repeat (3) @(negedge clk);
    inta_ack(isr_a1, vec, oe);
    pulse_ir(8'h40);
    repeat (4) @(negedge clk);
    checks++;
    if (int_out !== 1'b0 || isr_out !== 8'h04 || irr_out !== 8'h40) begin
      errors++;
      $display("FAIL nest_blocked got int=%b isr=%h irr=%h exp 0/04/40", int_out, isr_out, irr_out);
    end
    // Specific EOI for level 2: ISR clears the edge after the strobe.
    cfg_write(1'b0, 2'd1, 8'h62);
    checks++;
    if (isr_out !== 8'h00 || int_out !== 1'b0) begin
      errors++;
      $display("FAIL nest_eoi got isr=%h int=%b exp 00/0", isr_out, int_out);
    end
    @(negedge clk);
    checks++;
    if (int_out !== 1'b1) begin
      errors++;
      $display("FAIL nest_reassert got %b exp 1", int_out);
    end
    inta_ack(isr_a1, vec, oe);
    checks++;
    if (vec !== 8'h26) begin
      errors++;
      $display("FAIL nest_vector got %h exp 26", vec);
    end
  endtask

  task automatic test_level_spurious;
    logic [7:0] isr_a1, vec;
    logic oe;
    init(8'h1B, 8'h01);
    ir = 8'h02;
    repeat (3) @(negedge clk);
    checks++;
    if (int_out !== 1'b1 || irr_out !== 8'h02) begin
      errors++;
      $display("FAIL level_pend got int=%b irr=%h exp 1/02", int_out, irr_out);
    end
    ir = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (irr_out !== 8'h00) begin
      errors++;
      $display("FAIL level_drop got irr=%h exp 00", irr_out);
    end
    inta_ack(isr_a1, vec, oe);
    checks++;
    if (vec !== 8'h27 || isr_a1 !== 8'h00 || isr_out !== 8'h00) begin
      errors++;
      $display("FAIL level_spurious got vec=%h isr_a1=%h isr=%h exp 27/00/00", vec, isr_a1, isr_out);
    end
  endtask

  task automatic test_mask_pend;
    init(8'h13, 8'h01);
    pulse_ir(8'h10);
    @(negedge clk);
    cfg_write(1'b0, 2'd0, 8'h10);
    checks++;
    if (int_out !== 1'b1 || imr_out !== 8'h10) begin
      errors++;
      $display("FAIL mask_load got int=%b imr=%h exp 1/10", int_out, imr_out);
    end
    @(negedge clk);
    checks++;
    if (int_out !== 1'b0) begin
      errors++;
      $display("FAIL mask_drop got %b exp 0", int_out);
    end
  endtask

  task automatic test_aeoi_reset;
    logic [7:0] isr_a1, vec;
    logic oe;
    init(8'h13, 8'h03);
    pulse_ir(8'h01);
    repeat (3) @(negedge clk);
    inta_ack(isr_a1, vec, oe);
    checks++;
    if (isr_a1 !== 8'h01 || vec !== 8'h20 || isr_out !== 8'h00) begin
      errors++;
      $display("FAIL aeoi got isr_a1=%h vec=%h isr=%h exp 01/20/00", isr_a1, vec, isr_out);
    end
    // Second acknowledge, interrupted by reset while in ACK2.
    pulse_ir(8'h01);
    repeat (3) @(negedge clk);
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    inta_n = 1'b1;
    repeat (4) @(negedge clk);
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (vec_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_ack2 got oe=%b exp 1", vec_oe);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (vec_oe !== 1'b0 || int_out !== 1'b0 || vec_data !== 8'h00 || isr_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_async got oe=%b int=%b vec=%h isr=%h exp 0/0/00/00",
               vec_oe, int_out, vec_data, isr_out);
    end
    inta_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    // Uninitialized: a new request must not raise int_out or drive a vector.
    pulse_ir(8'h01);
    repeat (4) @(negedge clk);
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (int_out !== 1'b0 || vec_oe !== 1'b0) begin
      errors++;
      $display("FAIL rst_uninit got int=%b oe=%b exp 0/0", int_out, vec_oe);
    end
    inta_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    ir        = 8'h00;
    inta_n    = 1'b1;
    cfg_valid = 1'b0;
    cfg_type  = 1'b0;
    cfg_nr    = 2'd0;
    cfg_data  = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_priority();
    test_nesting();
    test_level_spurious();
    test_mask_pend();
    test_aeoi_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
